// File: rtl/ibex_ex_issue.sv
// ============================================================================
// ibex_ex_issue
// Issues one decoded instruction to the EX block, waits for its result with a
// cycle-bounded timeout and presents it on a writeback handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ibex_pkg;
    typedef enum logic [6:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SRA, ALU_SRL, ALU_SLL, ALU_LT, ALU_LTU
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM
    } md_op_e;
endpackage

module ibex_ex_issue #(
    parameter bit          RV32M      = 1'b1,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  ibex_pkg::alu_op_e   alu_op_i,
    input  logic [31:0]         operand_a_i,
    input  logic [31:0]         operand_b_i,
    input  logic                is_md_i,
    input  logic                is_div_i,
    input  ibex_pkg::md_op_e    md_op_i,
    input  logic [1:0]          md_signed_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rd_we_i,
    input  logic                flush_i,
    output ibex_pkg::alu_op_e   alu_operator_o,
    output logic [31:0]         alu_operand_a_o,
    output logic [31:0]         alu_operand_b_o,
    output ibex_pkg::md_op_e    multdiv_operator_o,
    output logic [1:0]          multdiv_signed_mode_o,
    output logic [31:0]         multdiv_operand_a_o,
    output logic [31:0]         multdiv_operand_b_o,
    output logic                mult_en_o,
    output logic                div_en_o,
    input  logic [31:0]         ex_result_i,
    input  logic                ex_valid_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [4:0]          wb_addr_o,
    output logic [31:0]         wb_data_o,
    output logic                wb_we_o,
    output logic                wb_err_o,
    output logic                busy_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_WB   = 2'd2;
    localparam logic [7:0] c_CNT_LAST = 8'(MD_TIMEOUT - 1);

    logic [1:0]        r_state;
    ibex_pkg::alu_op_e r_alu_op;
    ibex_pkg::md_op_e  r_md_op;
    logic [31:0]       r_op_a;
    logic [31:0]       r_op_b;
    logic [31:0]       r_wb_data;
    logic [1:0]        r_md_signed;
    logic [4:0]        r_rd_addr;
    logic              r_rd_we;
    logic              r_is_md;
    logic              r_is_div;
    logic              r_wb_err;
    logic [7:0]        r_cnt;

    logic w_idle;
    logic w_exec;
    logic w_wb;
    logic w_accept;
    logic w_illegal;

    assign w_idle    = (r_state == c_ST_IDLE);
    assign w_exec    = (r_state == c_ST_EXEC);
    assign w_wb      = (r_state == c_ST_WB);
    assign w_illegal = (RV32M == 1'b0) & is_md_i;

    assign instr_ready_o = ~flush_i & (w_idle | (w_wb & wb_ready_i));
    assign w_accept      = instr_valid_i & instr_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_alu_op    <= ibex_pkg::ALU_ADD;
            r_md_op     <= ibex_pkg::MD_OP_MULL;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_wb_data   <= 32'd0;
            r_md_signed <= 2'd0;
            r_rd_addr   <= 5'd0;
            r_rd_we     <= 1'b0;
            r_is_md     <= 1'b0;
            r_is_div    <= 1'b0;
            r_wb_err    <= 1'b0;
            r_cnt       <= 8'd0;
        end else if (flush_i) begin
            r_state <= c_ST_IDLE;
        end else if (w_accept) begin
            // Accept happens from IDLE or on the WB handshake; illegal M ops skip EX.
            r_alu_op    <= alu_op_i;
            r_md_op     <= md_op_i;
            r_op_a      <= operand_a_i;
            r_op_b      <= operand_b_i;
            r_md_signed <= md_signed_i;
            r_rd_addr   <= rd_addr_i;
            r_rd_we     <= rd_we_i;
            r_is_md     <= is_md_i;
            r_is_div    <= is_div_i;
            r_wb_data   <= 32'd0;
            r_wb_err    <= w_illegal;
            r_cnt       <= 8'd0;
            r_state     <= w_illegal ? c_ST_WB : c_ST_EXEC;
        end else begin
            case (r_state)
                c_ST_EXEC: begin
                    if (ex_valid_i) begin
                        r_wb_data <= ex_result_i;
                        r_state   <= c_ST_WB;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_wb_data <= 32'd0;
                        r_wb_err  <= 1'b1;
                        r_state   <= c_ST_WB;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_WB: begin
                    if (wb_ready_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign alu_operator_o        = r_alu_op;
    assign alu_operand_a_o       = r_op_a;
    assign alu_operand_b_o       = r_op_b;
    assign multdiv_operator_o    = r_md_op;
    assign multdiv_signed_mode_o = r_md_signed;
    assign multdiv_operand_a_o   = r_op_a;
    assign multdiv_operand_b_o   = r_op_b;
    assign mult_en_o             = w_exec & r_is_md & ~r_is_div;
    assign div_en_o              = w_exec & r_is_md & r_is_div;
    assign wb_valid_o            = w_wb;
    assign wb_addr_o             = r_rd_addr;
    assign wb_data_o             = r_wb_data;
    assign wb_err_o              = r_wb_err;
    assign wb_we_o               = r_rd_we & (r_rd_addr != 5'd0) & ~r_wb_err;
    assign busy_o                = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_ibex_ex_issue.sv
// ============================================================================
// tb_ibex_ex_issue
// Self-checking bench: directed table, randomized ops against a reference
// model, and hand-written flush / reset / back-to-back / RV32M=0 sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ibex_ex_issue;
    import ibex_pkg::*;

    localparam int MD_T = 64;

    typedef struct {
        alu_op_e     alu_op;
        logic [31:0] a;
        logic [31:0] b;
        logic        is_md;
        logic        is_div;
        md_op_e      md_op;
        logic [1:0]  sg;
        logic [4:0]  rd;
        logic        rd_we;
        int          lat;
        logic [31:0] res;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_we;
        int          exp_exec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, instr_valid, instr_valid0, flush, wb_ready, ex_valid;
    alu_op_e     alu_op;
    md_op_e      md_op;
    logic [31:0] a, b, ex_result;
    logic        is_md, is_div, rd_we;
    logic [1:0]  md_signed;
    logic [4:0]  rd;

    logic        instr_ready, mult_en, div_en, wb_valid, wb_we, wb_err, busy;
    alu_op_e     alu_operator;
    md_op_e      md_operator;
    logic [31:0] alu_a, alu_b, md_a, md_b, wb_data;
    logic [1:0]  md_sg;
    logic [4:0]  wb_addr;

    logic        instr_ready0, mult_en0, div_en0, wb_valid0, wb_we0, wb_err0, busy0;
    alu_op_e     alu_operator0;
    md_op_e      md_operator0;
    logic [31:0] alu_a0, alu_b0, md_a0, md_b0, wb_data0;
    logic [1:0]  md_sg0;
    logic [4:0]  wb_addr0;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vt[7];

    always #5 clk = ~clk;

    ibex_ex_issue #(.RV32M(1'b1), .MD_TIMEOUT(MD_T)) dut (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .alu_op_i(alu_op), .operand_a_i(a), .operand_b_i(b), .is_md_i(is_md), .is_div_i(is_div),
        .md_op_i(md_op), .md_signed_i(md_signed), .rd_addr_i(rd), .rd_we_i(rd_we), .flush_i(flush),
        .alu_operator_o(alu_operator), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
        .multdiv_operator_o(md_operator), .multdiv_signed_mode_o(md_sg),
        .multdiv_operand_a_o(md_a), .multdiv_operand_b_o(md_b),
        .mult_en_o(mult_en), .div_en_o(div_en), .ex_result_i(ex_result), .ex_valid_i(ex_valid),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .wb_we_o(wb_we), .wb_err_o(wb_err), .busy_o(busy)
    );

    ibex_ex_issue #(.RV32M(1'b0), .MD_TIMEOUT(MD_T)) dut0 (
        .clk_i(clk), .rst_i(rst), .instr_valid_i(instr_valid0), .instr_ready_o(instr_ready0),
        .alu_op_i(alu_op), .operand_a_i(a), .operand_b_i(b), .is_md_i(is_md), .is_div_i(is_div),
        .md_op_i(md_op), .md_signed_i(md_signed), .rd_addr_i(rd), .rd_we_i(rd_we), .flush_i(flush),
        .alu_operator_o(alu_operator0), .alu_operand_a_o(alu_a0), .alu_operand_b_o(alu_b0),
        .multdiv_operator_o(md_operator0), .multdiv_signed_mode_o(md_sg0),
        .multdiv_operand_a_o(md_a0), .multdiv_operand_b_o(md_b0),
        .mult_en_o(mult_en0), .div_en_o(div_en0), .ex_result_i(ex_result), .ex_valid_i(ex_valid),
        .wb_valid_o(wb_valid0), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr0), .wb_data_o(wb_data0),
        .wb_we_o(wb_we0), .wb_err_o(wb_err0), .busy_o(busy0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: the EX result arrives after lat EXEC cycles unless the
    // timeout budget runs out first; a result in the last budget cycle still counts.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_err  = (v.lat > MD_T);
        r.exp_exec = r.exp_err ? MD_T : v.lat;
        r.exp_data = r.exp_err ? 32'd0 : v.res;
        r.exp_we   = v.rd_we && (v.rd != 5'd0) && !r.exp_err;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        alu_op = v.alu_op; a = v.a; b = v.b; is_md = v.is_md; is_div = v.is_div;
        md_op = v.md_op; md_signed = v.sg; rd = v.rd; rd_we = v.rd_we; instr_valid = 1'b1;
    endtask

    // Issue one op to the RV32M=1 instance from IDLE and follow it to completion.
    task automatic run(input vec_t v, input int stall);
        int mc = 0, dc = 0, ec = 0;
        drive(v);
        @(negedge clk); chk("ready_idle", 32'(instr_ready), 1);
        @(posedge clk); #1;
        instr_valid = 1'b0; a = $urandom; b = $urandom; rd = 5'($urandom);
        for (int c = 1; c <= 300 && !wb_valid; c++) begin
            ex_valid  = (c == v.lat);
            ex_result = (c == v.lat) ? v.res : $urandom;
            @(negedge clk);
            if (mult_en) mc++;
            if (div_en) dc++;
            ec++;
            if (c == 1) begin
                chk("alu_a", alu_a, v.a);
                chk("alu_b", alu_b, v.b);
                chk("md_a", md_a, v.a);
                chk("md_b", md_b, v.b);
                chk("alu_op", 32'(alu_operator), 32'(v.alu_op));
                chk("md_op", 32'(md_operator), 32'(v.md_op));
                chk("md_signed", 32'(md_sg), 32'(v.sg));
            end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        chk("exec_cycles", ec, v.exp_exec);
        chk("mult_cycles", mc, (v.is_md && !v.is_div) ? v.exp_exec : 0);
        chk("div_cycles", dc, (v.is_md && v.is_div) ? v.exp_exec : 0);
        for (int s = 0; s <= stall; s++) begin
            wb_ready = (s == stall);
            @(negedge clk);
            chk("wb_valid", 32'(wb_valid), 1);
            chk("wb_addr", 32'(wb_addr), 32'(v.rd));
            chk("wb_data", wb_data, v.exp_data);
            chk("wb_err", 32'(wb_err), 32'(v.exp_err));
            chk("wb_we", 32'(wb_we), 32'(v.exp_we));
            chk("hold_alu_a", alu_a, v.a);
            @(posedge clk); #1;
        end
        wb_ready = 1'b0;
        @(negedge clk); chk("idle_after_wb", 32'({busy, wb_valid}), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v, v2;
        vt[0] = '{alu_op:ALU_ADD, a:5, b:7, is_md:0, is_div:0, md_op:MD_OP_MULL, sg:0, rd:3, rd_we:1,
                  lat:1, res:12, exp_data:12, exp_err:0, exp_we:1, exp_exec:1};
        vt[1] = '{alu_op:ALU_ADD, a:100, b:3, is_md:1, is_div:1, md_op:MD_OP_DIV, sg:3, rd:10, rd_we:1,
                  lat:37, res:32'hFFFF_FFFF, exp_data:32'hFFFF_FFFF, exp_err:0, exp_we:1, exp_exec:37};
        vt[2] = '{alu_op:ALU_XOR, a:6, b:9, is_md:1, is_div:0, md_op:MD_OP_MULL, sg:0, rd:4, rd_we:1,
                  lat:1000, res:77, exp_data:0, exp_err:1, exp_we:0, exp_exec:64};
        vt[3] = '{alu_op:ALU_OR, a:1, b:2, is_md:0, is_div:0, md_op:MD_OP_MULL, sg:0, rd:0, rd_we:1,
                  lat:1, res:32'h1234, exp_data:32'h1234, exp_err:0, exp_we:0, exp_exec:1};
        vt[4] = '{alu_op:ALU_ADD, a:8, b:8, is_md:1, is_div:1, md_op:MD_OP_REM, sg:1, rd:31, rd_we:1,
                  lat:64, res:32'hABCD, exp_data:32'hABCD, exp_err:0, exp_we:1, exp_exec:64};
        vt[5] = '{alu_op:ALU_ADD, a:3, b:3, is_md:1, is_div:0, md_op:MD_OP_MULH, sg:2, rd:9, rd_we:1,
                  lat:65, res:32'h5555, exp_data:0, exp_err:1, exp_we:0, exp_exec:64};
        vt[6] = '{alu_op:ALU_SUB, a:20, b:1, is_md:0, is_div:0, md_op:MD_OP_MULL, sg:0, rd:7, rd_we:0,
                  lat:3, res:19, exp_data:19, exp_err:0, exp_we:0, exp_exec:3};

        rst = 1'b1; instr_valid = 0; instr_valid0 = 0; flush = 0; wb_ready = 0; ex_valid = 0;
        ex_result = 0; drive(vt[0]); instr_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'({wb_valid, wb_we, wb_err, mult_en, div_en, busy}), 0);
        chk("rst_state0", 32'({wb_valid0, wb_err0, mult_en0, div_en0, busy0}), 0);
        chk("rst_data", wb_data | alu_a | alu_b | md_a | md_b | 32'(wb_addr) | 32'(md_sg), 0);
        chk("rst_alu_op", 32'(alu_operator), 32'(ALU_ADD));
        chk("rst_md_op", 32'(md_operator), 32'(MD_OP_MULL));
        rst = 1'b0;
        @(negedge clk); chk("ready_after_rst", 32'(instr_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run(vt[i], i % 3);

        for (int i = 0; i < 40; i++) begin
            v.is_md  = 1'($urandom_range(0, 1));
            v.is_div = 1'($urandom_range(0, 1));
            v.md_op  = md_op_e'(2'(v.is_div ? $urandom_range(2, 3) : $urandom_range(0, 1)));
            v.alu_op = alu_op_e'(7'($urandom_range(0, 9)));
            v.a = $urandom; v.b = $urandom; v.sg = 2'($urandom); v.rd = 5'($urandom);
            v.rd_we = 1'($urandom_range(0, 1)); v.res = $urandom;
            v.lat = !v.is_md ? int'($urandom_range(1, 3)) :
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 40));
            run(model(v), int'($urandom_range(0, 3)));
        end

        // Back-to-back: stalled WB payload, then handshake together with a new accept.
        v2 = vt[6]; v2.a = 9; v2.b = 4;
        drive(vt[0]);
        @(posedge clk); #1; instr_valid = 0; ex_valid = 1; ex_result = 12;
        @(posedge clk); #1; ex_valid = 0;
        for (int s = 0; s < 4; s++) begin
            wb_ready = (s == 3);
            if (s == 3) drive(v2);
            @(negedge clk);
            chk("b2b_payload", {wb_data[26:0], wb_addr}, {27'd12, 5'd3});
            chk("b2b_valid", 32'({wb_valid, busy}), 3);
            if (s == 3) chk("b2b_ready", 32'(instr_ready), 1);
            @(posedge clk); #1;
        end
        instr_valid = 0; wb_ready = 0; ex_valid = 1; ex_result = 5;
        @(negedge clk);
        chk("b2b_exec", 32'({busy, wb_valid}), 2);
        chk("b2b_new_a", alu_a, 9);
        @(posedge clk); #1; ex_valid = 0;
        @(negedge clk); chk("b2b_wb2", wb_data, 5); chk("b2b_wb2_we", 32'(wb_we), 0);
        wb_ready = 1;
        @(posedge clk); #1; wb_ready = 0;

        // Flush on the 5th EXEC cycle of a DIV, with a competing instruction pending.
        drive(vt[1]);
        @(posedge clk); #1; instr_valid = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin flush = 1; instr_valid = 1; end
            @(negedge clk); chk("flush_div_en", 32'(div_en), 1);
            if (c == 5) chk("flush_ready", 32'(instr_ready), 0);
            @(posedge clk); #1;
        end
        flush = 0; instr_valid = 0;
        @(negedge clk);
        chk("post_flush", 32'({div_en, busy, wb_valid}), 0);
        chk("post_flush_ready", 32'(instr_ready), 1);
        @(posedge clk); #1;

        // Flush beats a WB handshake: the pending writeback is dropped.
        drive(vt[0]);
        @(posedge clk); #1; instr_valid = 0; ex_valid = 1; ex_result = 12;
        @(posedge clk); #1; ex_valid = 0; flush = 1; wb_ready = 1;
        @(negedge clk); chk("flush_wb_valid", 32'(wb_valid), 1);
        @(posedge clk); #1; flush = 0; wb_ready = 0;
        @(negedge clk); chk("flush_wb_drop", 32'({busy, wb_valid}), 0);
        @(posedge clk); #1;

        // Reset (with flush) in the middle of a MUL abandons the op.
        drive(vt[2]);
        @(posedge clk); #1; instr_valid = 0;
        repeat (3) @(posedge clk);
        #1; rst = 1; flush = 1;
        @(posedge clk); #1; rst = 0; flush = 0;
        @(negedge clk);
        chk("rst_mid", 32'({busy, mult_en, wb_valid, wb_err}), 0);
        chk("rst_mid_data", alu_a | wb_data, 0);
        chk("rst_mid_op", 32'(alu_operator), 32'(ALU_ADD));
        @(posedge clk); #1;

        // RV32M=0: M ops finish illegal one cycle after accept, never enabling EX.
        for (int k = 0; k < 2; k++) begin
            v = vt[2]; v.rd = (k == 0) ? 5'd0 : 5'd5;
            if (k == 1) begin v.is_div = 1; v.md_op = MD_OP_DIV; end
            drive(v); instr_valid = 0; instr_valid0 = 1;
            @(negedge clk); chk("m0_ready", 32'(instr_ready0), 1);
            @(posedge clk); #1; instr_valid0 = 0;
            @(negedge clk);
            chk("m0_wb", 32'({wb_valid0, wb_err0, wb_we0, mult_en0, div_en0}), 5'b11000);
            chk("m0_data", wb_data0, 0);
            chk("m0_addr", 32'(wb_addr0), 32'(v.rd));
            wb_ready = 1;
            @(posedge clk); #1; wb_ready = 0;
            @(negedge clk); chk("m0_idle", 32'({busy0, wb_valid0}), 0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
